// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the two-port memory arbiter.
// The state enum, port count and default bus widths are used by the interface, top and grant logic.
package mem_arb_pkg;

    localparam int NUM_PORTS  = 2;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_ISSUE = 1'b1
    } arb_state_t;

    function automatic logic [NUM_PORTS-1:0] port_onehot(input logic port);
        port_onehot = port ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester handshakes and the memory-side bus for mem_port_arbiter.
// The slave modport is the arbiter's view; the master modport is the requesters' and memory's view.
interface mem_port_arbiter_if
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) ();

    logic [NUM_PORTS-1:0]        reqValid;
    logic [NUM_PORTS-1:0]        reqWrite;
    logic [NUM_PORTS*ADDR_W-1:0] reqAddr;
    logic [NUM_PORTS*DATA_W-1:0] reqWdata;
    logic [NUM_PORTS-1:0]        reqReady;
    logic [NUM_PORTS-1:0]        rspValid;
    logic [DATA_W-1:0]           rspData;
    logic [ADDR_W-1:0]           memAddress;
    logic [DATA_W-1:0]           memWriteData;
    logic                        memWrite;
    logic [DATA_W-1:0]           memReadData;

    modport master (
        output reqValid, reqWrite, reqAddr, reqWdata, memReadData,
        input  reqReady, rspValid, rspData, memAddress, memWriteData, memWrite
    );

    modport slave (
        input  reqValid, reqWrite, reqAddr, reqWdata, memReadData,
        output reqReady, rspValid, rspData, memAddress, memWriteData, memWrite
    );

endinterface

// File: rtl/mem_port_arbiter_rr_arb2.sv
// Combinational two-way grant: a lone request always wins; on a tie the pointer
// picks the winner, unless fixed priority forces port 0.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [NUM_PORTS-1:0] i_valid,
    input  logic                 i_ptr,
    input  logic                 i_fixed_prio,
    output logic [NUM_PORTS-1:0] o_gnt
);

    always_comb begin
        o_gnt = 2'b00;
        case (i_valid)
            2'b01:   o_gnt = 2'b01;
            2'b10:   o_gnt = 2'b10;
            2'b11:   o_gnt = port_onehot(i_ptr & ~i_fixed_prio);
            default: o_gnt = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU (port 0) and the loader/DMA (port 1).
// Each accepted op is issued the next cycle and answered the cycle after that.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter bit FIXED_PRIO = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic                 r_rr_ptr;
    logic                 r_owner;
    logic                 r_write;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_wdata;
    logic                 r_mem_write;
    logic [NUM_PORTS-1:0] r_rsp_valid;
    logic [DATA_W-1:0]    r_rsp_data;

    logic [NUM_PORTS-1:0] w_gnt;
    logic                 w_accept;
    logic                 w_sel;
    logic [ADDR_W-1:0]    w_addr;
    logic [DATA_W-1:0]    w_wdata;
    logic                 w_write;

    rr_arb2 u_rr_arb2 (
        .i_valid      (bus.reqValid),
        .i_ptr        (r_rr_ptr),
        .i_fixed_prio (FIXED_PRIO),
        .o_gnt        (w_gnt)
    );

    // Ready is offered only while idle and out of reset, so nothing is granted during reset.
    always_comb begin
        bus.reqReady = {NUM_PORTS{1'b0}};
        w_accept     = 1'b0;
        if (reset && (r_state == ARB_IDLE)) begin
            bus.reqReady = w_gnt;
            w_accept     = |w_gnt;
        end else begin
            bus.reqReady = {NUM_PORTS{1'b0}};
            w_accept     = 1'b0;
        end
    end

    always_comb begin
        w_sel   = w_gnt[1];
        w_addr  = bus.reqAddr[ADDR_W-1:0];
        w_wdata = bus.reqWdata[DATA_W-1:0];
        w_write = bus.reqWrite[0];
        if (w_sel) begin
            w_addr  = bus.reqAddr[ADDR_W +: ADDR_W];
            w_wdata = bus.reqWdata[DATA_W +: DATA_W];
            w_write = bus.reqWrite[1];
        end else begin
            w_addr  = bus.reqAddr[ADDR_W-1:0];
            w_wdata = bus.reqWdata[DATA_W-1:0];
            w_write = bus.reqWrite[0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ARB_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ARB_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ARB_ISSUE;
                end else begin
                    w_state_nxt = ARB_IDLE;
                end
            end
            ARB_ISSUE: w_state_nxt = ARB_IDLE;
            default:   w_state_nxt = ARB_IDLE;
        endcase
    end

    // The pointer moves only on an accept and always lands on the port that just lost.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rr_ptr    <= 1'b0;
            r_owner     <= 1'b0;
            r_write     <= 1'b0;
            r_mem_addr  <= {ADDR_W{1'b0}};
            r_mem_wdata <= {DATA_W{1'b0}};
            r_mem_write <= 1'b0;
            r_rsp_valid <= {NUM_PORTS{1'b0}};
            r_rsp_data  <= {DATA_W{1'b0}};
        end else begin
            r_mem_write <= 1'b0;
            r_rsp_valid <= {NUM_PORTS{1'b0}};
            if (w_accept) begin
                r_mem_addr  <= w_addr;
                r_mem_wdata <= w_wdata;
                r_mem_write <= w_write;
                r_write     <= w_write;
                r_owner     <= w_sel;
                if (!FIXED_PRIO) begin
                    r_rr_ptr <= ~w_sel;
                end
            end
            if (r_state == ARB_ISSUE) begin
                r_rsp_valid <= port_onehot(r_owner);
                r_rsp_data  <= r_write ? {DATA_W{1'b0}} : bus.memReadData;
            end
        end
    end

    assign bus.memAddress   = r_mem_addr;
    assign bus.memWriteData = r_mem_wdata;
    assign bus.memWrite     = r_mem_write;
    assign bus.rspValid     = r_rsp_valid;
    assign bus.rspData      = r_rsp_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Drives a round-robin and a fixed-priority arbiter side by side and compares both
// against a transaction-level model of grant choice, latency and memory contents.
module tb_mem_port_arbiter;

    localparam int M_IDLE   = 0;
    localparam int M_RAND   = 1;
    localparam int M_CONT   = 2;
    localparam int M_DIRECT = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [1:0]  t_valid [2];
    logic [1:0]  t_write [2];
    logic [63:0] t_addr  [2];
    logic [63:0] t_wdata [2];

    logic [1:0]  o_ready     [2];
    logic [1:0]  o_rsp_valid [2];
    logic [31:0] o_rsp_data  [2];
    logic [31:0] o_mem_addr  [2];
    logic [31:0] o_mem_wdata [2];
    logic        o_mem_write [2];

    logic [31:0] mem [2][64];
    logic        ld_en;
    logic [5:0]  ld_idx;
    logic [31:0] ld_val [2];

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus0 ();
    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus1 ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b0)) u_dut_rr (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus0)
    );

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .FIXED_PRIO(1'b1)) u_dut_fp (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus1)
    );

    assign bus0.reqValid    = t_valid[0];
    assign bus0.reqWrite    = t_write[0];
    assign bus0.reqAddr     = t_addr[0];
    assign bus0.reqWdata    = t_wdata[0];
    assign bus0.memReadData = mem[0][bus0.memAddress[7:2]];
    assign o_ready[0]       = bus0.reqReady;
    assign o_rsp_valid[0]   = bus0.rspValid;
    assign o_rsp_data[0]    = bus0.rspData;
    assign o_mem_addr[0]    = bus0.memAddress;
    assign o_mem_wdata[0]   = bus0.memWriteData;
    assign o_mem_write[0]   = bus0.memWrite;

    assign bus1.reqValid    = t_valid[1];
    assign bus1.reqWrite    = t_write[1];
    assign bus1.reqAddr     = t_addr[1];
    assign bus1.reqWdata    = t_wdata[1];
    assign bus1.memReadData = mem[1][bus1.memAddress[7:2]];
    assign o_ready[1]       = bus1.reqReady;
    assign o_rsp_valid[1]   = bus1.rspValid;
    assign o_rsp_data[1]    = bus1.rspData;
    assign o_mem_addr[1]    = bus1.memAddress;
    assign o_mem_wdata[1]   = bus1.memWriteData;
    assign o_mem_write[1]   = bus1.memWrite;

    // Word-indexed memories, preloaded by the bench during reset and written by each arbiter.
    always @(posedge clk) begin
        if (ld_en) begin
            mem[0][ld_idx] <= ld_val[0];
            mem[1][ld_idx] <= ld_val[1];
        end
        if (o_mem_write[0]) mem[0][o_mem_addr[0][7:2]] <= o_mem_wdata[0];
        if (o_mem_write[1]) mem[1][o_mem_addr[1][7:2]] <= o_mem_wdata[1];
    end

    // Reference model state (k = 0 round-robin instance, k = 1 fixed-priority instance)
    int          mode [2][2];
    int          m_pref [2];
    bit          m_iss_v [2];
    bit          m_iss_own [2];
    bit          m_iss_wr [2];
    logic [31:0] m_iss_addr [2];
    logic [31:0] m_iss_wdata [2];
    logic [31:0] e_mem_addr [2];
    logic [31:0] e_mem_wdata [2];
    logic        e_mem_write [2];
    logic [1:0]  e_rsp_valid [2];
    logic [31:0] e_rsp_data [2];
    logic [31:0] ref_mem [2][64];
    bit          acc [2][2];
    int          g_port [2][64];
    int          g_cnt [2];

    logic [1:0]  d_go;
    logic [1:0]  d_write;
    logic [31:0] d_addr [2];
    logic [31:0] d_wdata [2];

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s[dut%0d] cyc=%0d got=%h want=%h", tag, k, cyc, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_pref[k]      = 0;
            m_iss_v[k]     = 1'b0;
            e_mem_addr[k]  = 32'h0;
            e_mem_wdata[k] = 32'h0;
            e_mem_write[k] = 1'b0;
            e_rsp_valid[k] = 2'b00;
            e_rsp_data[k]  = 32'h0;
            acc[k][0]      = 1'b0;
            acc[k][1]      = 1'b0;
        end
    endtask

    task automatic check_regs(input int k);
        chk("memWrite", k, 32'(o_mem_write[k]), 32'(e_mem_write[k]));
        chk("memAddress", k, o_mem_addr[k], e_mem_addr[k]);
        chk("memWriteData", k, o_mem_wdata[k], e_mem_wdata[k]);
        chk("rspValid", k, 32'(o_rsp_valid[k]), 32'(e_rsp_valid[k]));
        chk("rspData", k, o_rsp_data[k], e_rsp_data[k]);
    endtask

    task automatic drive(input int k);
        for (int p = 0; p < 2; p++) begin
            if (acc[k][p]) begin
                t_valid[k][p] = 1'b0;
                acc[k][p]     = 1'b0;
            end
            case (mode[k][p])
                M_IDLE: t_valid[k][p] = 1'b0;
                M_RAND: begin
                    if (!t_valid[k][p]) begin
                        if ($urandom_range(1, 0) == 1) begin
                            t_valid[k][p]            = 1'b1;
                            t_write[k][p]            = 1'($urandom);
                            t_addr[k][p*32 +: 32]    = {24'h0, 6'($urandom), 2'b00};
                            t_wdata[k][p*32 +: 32]   = $urandom;
                        end
                    end else if ($urandom_range(7, 0) == 0) begin
                        t_valid[k][p] = 1'b0;
                    end
                end
                M_CONT: begin
                    t_valid[k][p]          = 1'b1;
                    t_write[k][p]          = 1'b0;
                    t_addr[k][p*32 +: 32]  = (p == 0) ? 32'h20 : 32'h24;
                    t_wdata[k][p*32 +: 32] = 32'h0;
                end
                default: begin
                    if (d_go[p]) begin
                        t_valid[k][p]          = 1'b1;
                        t_write[k][p]          = d_write[p];
                        t_addr[k][p*32 +: 32]  = d_addr[p];
                        t_wdata[k][p*32 +: 32] = d_wdata[p];
                    end
                end
            endcase
        end
    endtask

    // Decide the winner from the arbitration rules, then schedule what the next cycle must show.
    task automatic eval(input int k);
        int         win;
        logic [1:0] exp_ready;
        logic [5:0] idx;
        win = -1;
        if (!m_iss_v[k]) begin
            case (t_valid[k])
                2'b01:   win = 0;
                2'b10:   win = 1;
                2'b11:   win = (k == 1) ? 0 : m_pref[k];
                default: win = -1;
            endcase
        end
        exp_ready = (win == 0) ? 2'b01 : ((win == 1) ? 2'b10 : 2'b00);
        chk("reqReady", k, 32'(o_ready[k]), 32'(exp_ready));
        for (int p = 0; p < 2; p++) begin
            if (t_valid[k][p] && o_ready[k][p] && (g_cnt[k] < 64)) begin
                g_port[k][g_cnt[k]] = p;
                g_cnt[k]++;
            end
        end
        if (m_iss_v[k]) begin
            idx            = m_iss_addr[k][7:2];
            e_rsp_valid[k] = m_iss_own[k] ? 2'b10 : 2'b01;
            if (m_iss_wr[k]) begin
                e_rsp_data[k]   = 32'h0;
                ref_mem[k][idx] = m_iss_wdata[k];
            end else begin
                e_rsp_data[k] = ref_mem[k][idx];
            end
        end else begin
            e_rsp_valid[k] = 2'b00;
        end
        if (win >= 0) begin
            e_mem_write[k] = t_write[k][win];
            e_mem_addr[k]  = t_addr[k][win*32 +: 32];
            e_mem_wdata[k] = t_wdata[k][win*32 +: 32];
            m_iss_v[k]     = 1'b1;
            m_iss_own[k]   = (win == 1);
            m_iss_wr[k]    = t_write[k][win];
            m_iss_addr[k]  = t_addr[k][win*32 +: 32];
            m_iss_wdata[k] = t_wdata[k][win*32 +: 32];
            if (k == 0) m_pref[k] = 1 - win;
            acc[k][win] = 1'b1;
        end else begin
            e_mem_write[k] = 1'b0;
            m_iss_v[k]     = 1'b0;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) check_regs(k);
        for (int k = 0; k < 2; k++) drive(k);
        d_go = 2'b00;
        #1;
        for (int k = 0; k < 2; k++) eval(k);
    endtask

    task automatic reset_tick();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) t_valid[k] = 2'($urandom);
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("rst_reqReady", k, 32'(o_ready[k]), 32'h0);
            chk("rst_rspValid", k, 32'(o_rsp_valid[k]), 32'h0);
            chk("rst_memWrite", k, 32'(o_mem_write[k]), 32'h0);
            chk("rst_memAddress", k, o_mem_addr[k], 32'h0);
        end
    endtask

    task automatic set_modes(input int m);
        for (int k = 0; k < 2; k++) begin
            mode[k][0] = m;
            mode[k][1] = m;
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 2; k++) begin
            t_valid[k] = 2'b00;
            t_write[k] = 2'b00;
            t_addr[k]  = 64'h0;
            t_wdata[k] = 64'h0;
            g_cnt[k]   = 0;
            for (int i = 0; i < 64; i++) g_port[k][i] = 0;
        end
        d_go    = 2'b00;
        d_write = 2'b00;
        ld_en   = 1'b0;
        ld_idx  = 6'd0;
        set_modes(M_IDLE);
        model_reset();

        // Reset with random request traffic while the memories are preloaded
        for (int i = 0; i < 64; i++) begin
            reset_tick();
            ld_en  = 1'b1;
            ld_idx = 6'(i);
            for (int k = 0; k < 2; k++) begin
                ld_val[k]     = (i == 3) ? 32'h07802683 : $urandom;
                ref_mem[k][i] = ld_val[k];
            end
        end
        @(negedge clk);
        ld_en = 1'b0;
        for (int k = 0; k < 2; k++) t_valid[k] = 2'b00;
        rst_n = 1'b1;

        // Port 0 read of word 3
        set_modes(M_DIRECT);
        d_go = 2'b01; d_write = 2'b00; d_addr[0] = 32'h0C; d_wdata[0] = 32'h5A5A5A5A;
        tick();
        for (int k = 0; k < 2; k++) chk("t2_reqReady", k, 32'(o_ready[k]), 32'h1);
        tick();
        for (int k = 0; k < 2; k++) chk("t2_memAddress", k, o_mem_addr[k], 32'h0C);
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t2_rspValid", k, 32'(o_rsp_valid[k]), 32'h1);
            chk("t2_rspData", k, o_rsp_data[k], 32'h07802683);
        end

        // Port 1 write of all-ones to word 30
        d_go = 2'b10; d_write = 2'b10; d_addr[1] = 32'h78; d_wdata[1] = 32'hFFFFFFFF;
        tick();
        for (int k = 0; k < 2; k++) chk("t3_reqReady", k, 32'(o_ready[k]), 32'h2);
        tick();
        for (int k = 0; k < 2; k++) chk("t3_memWrite_hi", k, 32'(o_mem_write[k]), 32'h1);
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t3_memWrite_lo", k, 32'(o_mem_write[k]), 32'h0);
            chk("t3_rspValid", k, 32'(o_rsp_valid[k]), 32'h2);
            chk("t3_rspData", k, o_rsp_data[k], 32'h0);
            chk("t3_mem30", k, mem[k][30], 32'hFFFFFFFF);
        end

        // Both ports contend: alternation on dut0, port 0 always on dut1
        g_cnt[0] = 0;
        g_cnt[1] = 0;
        set_modes(M_CONT);
        for (int i = 0; (i < 40) && !((g_cnt[0] >= 6) && (g_cnt[1] >= 6)); i++) tick();
        for (int k = 0; k < 2; k++) chk("t45_accepts", k, 32'(g_cnt[k] >= 6), 32'h1);
        for (int i = 0; i < 6; i++) begin
            chk("t4_grant_rr", 0, 32'(g_port[0][i]), 32'(i % 2));
            chk("t5_grant_fp", 1, 32'(g_port[1][i]), 32'h0);
        end
        mode[0][0] = M_IDLE;
        mode[0][1] = M_IDLE;
        mode[1][0] = M_IDLE;
        for (int i = 0; (i < 10) && (g_cnt[1] < 7); i++) tick();
        chk("t5_port1_after", 1, 32'(g_port[1][6]), 32'h1);

        // Randomized traffic on both instances
        set_modes(M_RAND);
        for (int i = 0; i < 600; i++) tick();
        set_modes(M_IDLE);
        for (int i = 0; i < 4; i++) tick();

        // Reset asserted while a write is being issued
        set_modes(M_DIRECT);
        d_go = 2'b01; d_write = 2'b01; d_addr[0] = 32'h40; d_wdata[0] = 32'h12345678;
        tick();
        @(negedge clk);
        cyc++;
        for (int k = 0; k < 2; k++) begin
            check_regs(k);
            chk("t6_memWrite_issue", k, 32'(o_mem_write[k]), 32'h1);
        end
        rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("t6_memWrite_drop", k, 32'(o_mem_write[k]), 32'h0);
            chk("t6_rspValid_drop", k, 32'(o_rsp_valid[k]), 32'h0);
        end
        model_reset();
        for (int i = 0; i < 3; i++) reset_tick();
        @(negedge clk);
        for (int k = 0; k < 2; k++) t_valid[k] = 2'b00;
        rst_n = 1'b1;
        set_modes(M_IDLE);
        for (int i = 0; i < 3; i++) tick();
        for (int k = 0; k < 2; k++) chk("t6_mem16_kept", k, mem[k][16], ref_mem[k][16]);
        set_modes(M_DIRECT);
        d_go = 2'b10; d_write = 2'b00; d_addr[1] = 32'h40; d_wdata[1] = 32'h0;
        tick();
        for (int k = 0; k < 2; k++) chk("t6_reqReady", k, 32'(o_ready[k]), 32'h2);
        tick();
        tick();
        for (int k = 0; k < 2; k++) begin
            chk("t6_rspValid", k, 32'(o_rsp_valid[k]), 32'h2);
            chk("t6_rspData", k, o_rsp_data[k], ref_mem[k][16]);
        end

        // Memory image must match the model after all traffic
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 64; i++) chk("mem_final", k, mem[k][i], ref_mem[k][i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
